multi_ch_pulse_gen: RTL and testbench

//  Parametrised N-channel pulse generator: per-channel period, delay and high-time, in prescaled ticks.

---
 rtl/pulse_gen_pkg.sv | 23 ++
 rtl/ch_pulse_core.sv | 151 +++++++++++++++
 rtl/multi_ch_pulse_gen.sv | 61 ++++++
 tb/tb_multi_ch_pulse_gen.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_gen_pkg.sv
// Shared types, constants and bus-slicing helper for the multi-channel pulse generator.
package pulse_gen_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_t;

    // Guard bits added to counter width for the active-window compare.
    localparam int unsigned CMP_GUARD_W = 1;

    // Widest packed per-channel bus and widest single field the helper handles.
    localparam int unsigned MAX_BUS_W   = 1024;
    localparam int unsigned MAX_FIELD_W = 32;

    // Extract field idx (each w bits wide) from a packed per-channel bus.
    function automatic logic [MAX_FIELD_W-1:0] ch_field(input logic [MAX_BUS_W-1:0] bus,
                                                        input int unsigned       idx,
                                                        input int unsigned       w);
        return MAX_FIELD_W'(bus >> (idx * w));
    endfunction

endpackage

// File: rtl/ch_pulse_core.sv
// One pulse channel: IDLE/RUN FSM, tick counter, shadow/active config and registered output.
module ch_pulse_core
    import pulse_gen_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             tick,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_delay,
    input  logic [CNT_W-1:0] cfg_width,
    input  logic             cfg_pol,
    input  logic             cfg_oneshot,
    input  logic             cfg_load,
    input  logic             ch_en,
    input  logic             trig,
    output logic             ch_out,
    output logic             ch_busy,
    output logic             ch_wrap
);

    localparam int unsigned CMP_W = CNT_W + CMP_GUARD_W;

    typedef struct packed {
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] delay;
        logic [CNT_W-1:0] width;
        logic             pol;
        logic             oneshot;
    } cfg_t;

    cfg_t             act_q;
    cfg_t             pend_q;
    logic             pend_v_q;
    cfg_t             cfg_in;
    cfg_t             cfg_nxt;
    ch_state_t        state_q;
    ch_state_t        state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             en_q;
    logic             out_q;
    logic             wrap_q;
    logic             raw;
    logic             last_tick;
    logic             start;
    logic             wrap_go;
    logic             apply;
    logic [CMP_W-1:0] cnt_x;
    logic [CMP_W-1:0] dly_x;
    logic [CMP_W-1:0] wid_x;

    // Config selection and active-window evaluation for the current count.
    always_comb begin
        cfg_in.period  = cfg_period;
        cfg_in.delay   = cfg_delay;
        cfg_in.width   = cfg_width;
        cfg_in.pol     = cfg_pol;
        cfg_in.oneshot = cfg_oneshot;
        // A load in the same cycle as a period start wins over older pending values.
        cfg_nxt = cfg_load ? cfg_in : (pend_v_q ? pend_q : act_q);

        cnt_x = CMP_W'(cnt_q);
        dly_x = CMP_W'(act_q.delay);
        wid_x = CMP_W'(act_q.width);
        raw   = (cnt_x >= dly_x) && ((cnt_x - dly_x) < wid_x);

        last_tick = tick && (cnt_q == (act_q.period - CNT_W'(1)));
    end

    // Next-state logic: start conditions, wrap handling and config application points.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        wrap_go = 1'b0;
        apply   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                apply = 1'b1;
                if (ch_en && (cfg_nxt.period != '0) &&
                    (cfg_nxt.oneshot ? trig : !en_q)) begin
                    state_d = ST_RUN;
                    start   = 1'b1;
                end
            end
            ST_RUN: begin
                if (!ch_en) begin
                    state_d = ST_IDLE;
                end else if (last_tick) begin
                    if (act_q.oneshot) begin
                        state_d = ST_IDLE;
                    end else begin
                        apply = 1'b1;
                        if (cfg_nxt.period == '0) begin
                            state_d = ST_IDLE;
                        end else begin
                            wrap_go = 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counter, config registers and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            en_q     <= 1'b0;
            act_q    <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            out_q    <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= ch_en;
            wrap_q  <= start || wrap_go;

            if (apply) begin
                act_q    <= cfg_nxt;
                pend_v_q <= 1'b0;
            end else if (cfg_load) begin
                pend_q   <= cfg_in;
                pend_v_q <= 1'b1;
            end

            if ((state_d == ST_IDLE) || start) begin
                cnt_q <= '0;
            end else if (tick) begin
                cnt_q <= last_tick ? '0 : cnt_q + CNT_W'(1);
            end

            // The last one-shot tick still drives its evaluated level before going inactive.
            if ((state_q == ST_RUN) && ch_en && tick) begin
                out_q <= raw ^ act_q.pol;
            end else if (state_q == ST_IDLE) begin
                out_q <= cfg_nxt.pol;
            end else if (!ch_en) begin
                out_q <= act_q.pol;
            end
        end
    end

    assign ch_out  = out_q;
    assign ch_busy = (state_q == ST_RUN);
    assign ch_wrap = wrap_q;

endmodule

// File: rtl/multi_ch_pulse_gen.sv
// N-channel pulse generator: shared tick prescaler feeding one ch_pulse_core per channel.
module multi_ch_pulse_gen
    import pulse_gen_pkg::*;
#(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned PRESC_W = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [PRESC_W-1:0]      presc_div,
    input  logic [NUM_CH*CNT_W-1:0] cfg_period,
    input  logic [NUM_CH*CNT_W-1:0] cfg_delay,
    input  logic [NUM_CH*CNT_W-1:0] cfg_width,
    input  logic [NUM_CH-1:0]       cfg_pol,
    input  logic [NUM_CH-1:0]       cfg_oneshot,
    input  logic [NUM_CH-1:0]       cfg_load,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [NUM_CH-1:0]       trig,
    output logic [NUM_CH-1:0]       ch_out,
    output logic [NUM_CH-1:0]       ch_busy,
    output logic [NUM_CH-1:0]       ch_wrap
);

    logic [PRESC_W-1:0] pcnt;
    logic               tick;

    // A shrinking divider must not strand pcnt above it, hence >= rather than ==.
    assign tick = (pcnt >= presc_div);

    // Shared prescaler counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pcnt <= '0;
        end else begin
            pcnt <= tick ? '0 : pcnt + PRESC_W'(1);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ch_pulse_core #(
            .CNT_W(CNT_W)
        ) u_core (
            .clk        (clk),
            .rstn       (rstn),
            .tick       (tick),
            .cfg_period (CNT_W'(ch_field(MAX_BUS_W'(cfg_period), i, CNT_W))),
            .cfg_delay  (CNT_W'(ch_field(MAX_BUS_W'(cfg_delay),  i, CNT_W))),
            .cfg_width  (CNT_W'(ch_field(MAX_BUS_W'(cfg_width),  i, CNT_W))),
            .cfg_pol    (cfg_pol[i]),
            .cfg_oneshot(cfg_oneshot[i]),
            .cfg_load   (cfg_load[i]),
            .ch_en      (ch_en[i]),
            .trig       (trig[i]),
            .ch_out     (ch_out[i]),
            .ch_busy    (ch_busy[i]),
            .ch_wrap    (ch_wrap[i])
        );
    end

endmodule

// File: tb/tb_multi_ch_pulse_gen.sv
// Directed self-checking bench for multi_ch_pulse_gen (4 channels, 16-bit counters).
module tb_multi_ch_pulse_gen;

    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] presc_div;
    logic [63:0] cfg_period;
    logic [63:0] cfg_delay;
    logic [63:0] cfg_width;
    logic [3:0]  cfg_pol;
    logic [3:0]  cfg_oneshot;
    logic [3:0]  cfg_load;
    logic [3:0]  ch_en;
    logic [3:0]  trig;
    logic [3:0]  ch_out;
    logic [3:0]  ch_busy;
    logic [3:0]  ch_wrap;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    multi_ch_pulse_gen #(
        .NUM_CH (4),
        .CNT_W  (16),
        .PRESC_W(16)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .presc_div  (presc_div),
        .cfg_period (cfg_period),
        .cfg_delay  (cfg_delay),
        .cfg_width  (cfg_width),
        .cfg_pol    (cfg_pol),
        .cfg_oneshot(cfg_oneshot),
        .cfg_load   (cfg_load),
        .ch_en      (ch_en),
        .trig       (trig),
        .ch_out     (ch_out),
        .ch_busy    (ch_busy),
        .ch_wrap    (ch_wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [15:0] div);
        rstn        = 1'b0;
        presc_div   = div;
        cfg_period  = '0;
        cfg_delay   = '0;
        cfg_width   = '0;
        cfg_pol     = '0;
        cfg_oneshot = '0;
        cfg_load    = '0;
        ch_en       = '0;
        trig        = '0;
        step();
        step();
        rstn = 1'b1;
    endtask

    task automatic set_cfg(input int ch, input logic [15:0] p, input logic [15:0] d,
                           input logic [15:0] w, input logic pol, input logic os);
        cfg_period[ch*16 +: 16] = p;
        cfg_delay[ch*16 +: 16]  = d;
        cfg_width[ch*16 +: 16]  = w;
        cfg_pol[ch]             = pol;
        cfg_oneshot[ch]         = os;
    endtask

    task automatic load(input int ch, input logic [15:0] p, input logic [15:0] d,
                        input logic [15:0] w, input logic pol, input logic os);
        set_cfg(ch, p, d, w, pol, os);
        cfg_load[ch] = 1'b1;
        step();
        cfg_load = '0;
    endtask

    initial begin
        logic [3:0] pat4;
        logic [7:0] pat8;
        logic [4:0] pat_os;
        logic [1:0] f_out  [0:10];
        logic [1:0] f_busy [0:10];
        logic [3:0] e_out;
        logic [3:0] e_wrap;

        pat4   = 4'b0110;      // period 4, delay 1, width 2: cnt 1,2 active
        pat8   = 8'b0000_0110; // period 8, delay 1, width 2
        pat_os = 5'b00111;     // period 5, delay 0, width 3
        f_out  = '{2'b00, 2'b11, 2'b10, 2'b00, 2'b00, 2'b10, 2'b11, 2'b00, 2'b00, 2'b10, 2'b11};
        f_busy = '{2'b11, 2'b11, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};

        // Reset values
        do_reset(16'd0);
        rstn = 1'b0;
        #1;
        check("reset ch_out", 32'(ch_out), 32'h0);
        check("reset ch_busy", 32'(ch_busy), 32'h0);
        check("reset ch_wrap", 32'(ch_wrap), 32'h0);

        // A: continuous, no prescale -> 0110 repeating, wrap every 4 clk
        do_reset(16'd0);
        load(0, 16'd4, 16'd1, 16'd2, 1'b0, 1'b0);
        ch_en[0] = 1'b1;
        step();
        check("A start busy", 32'(ch_busy[0]), 32'h1);
        check("A start wrap", 32'(ch_wrap[0]), 32'h1);
        check("A start out", 32'(ch_out[0]), 32'h0);
        for (int n = 0; n < 12; n++) begin
            step();
            check($sformatf("A out n=%0d", n), 32'(ch_out[0]), 32'(pat4[n % 4]));
            check($sformatf("A wrap n=%0d", n), 32'(ch_wrap[0]), 32'((n % 4) == 3));
        end

        // B: presc_div=2 -> each level held 3 clk, period 12 clk
        do_reset(16'd2);
        load(0, 16'd4, 16'd1, 16'd2, 1'b0, 1'b0);
        ch_en[0] = 1'b1;
        step();
        check("B start wrap", 32'(ch_wrap[0]), 32'h1);
        for (int n = 0; n < 24; n++) begin
            step();
            check($sformatf("B out n=%0d", n), 32'(ch_out[0]), 32'(pat4[(n / 3) % 4]));
            check($sformatf("B wrap n=%0d", n), 32'(ch_wrap[0]), 32'((n % 12) == 9));
        end

        // C: period 8 loaded mid-period takes effect at the next wrap
        do_reset(16'd0);
        load(0, 16'd4, 16'd1, 16'd2, 1'b0, 1'b0);
        ch_en[0] = 1'b1;
        step();
        for (int n = 0; n < 20; n++) begin
            if (n == 2) begin
                set_cfg(0, 16'd8, 16'd1, 16'd2, 1'b0, 1'b0);
                cfg_load[0] = 1'b1;
            end else begin
                cfg_load = '0;
            end
            step();
            if (n < 4) begin
                check($sformatf("C out n=%0d", n), 32'(ch_out[0]), 32'(pat4[n]));
            end else begin
                check($sformatf("C out n=%0d", n), 32'(ch_out[0]), 32'(pat8[(n - 4) % 8]));
            end
            check($sformatf("C wrap n=%0d", n), 32'(ch_wrap[0]),
                  32'((n == 3) || ((n >= 4) && (((n - 4) % 8) == 7))));
        end
        cfg_load = '0;

        // D: one-shot period 5 delay 0 width 3, retrigger while busy ignored
        do_reset(16'd0);
        load(0, 16'd5, 16'd0, 16'd3, 1'b0, 1'b1);
        ch_en[0] = 1'b1;
        step();
        check("D no trig busy", 32'(ch_busy[0]), 32'h0);
        trig[0] = 1'b1;
        step();
        trig[0] = 1'b0;
        check("D start busy", 32'(ch_busy[0]), 32'h1);
        for (int n = 0; n < 8; n++) begin
            trig[0] = (n == 1);
            step();
            check($sformatf("D out n=%0d", n), 32'(ch_out[0]), 32'((n < 5) ? pat_os[n] : 1'b0));
            check($sformatf("D busy n=%0d", n), 32'(ch_busy[0]), 32'(n < 4));
            check($sformatf("D wrap n=%0d", n), 32'(ch_wrap[0]), 32'h0);
        end
        trig = '0;

        // E: boundaries on all channels at once
        do_reset(16'd0);
        load(0, 16'd4, 16'd3, 16'd5, 1'b0, 1'b0); // delay+width past period end
        load(1, 16'd0, 16'd0, 16'd1, 1'b0, 1'b0); // period 0
        load(2, 16'd4, 16'd1, 16'd2, 1'b1, 1'b0); // active-low
        load(3, 16'd3, 16'd0, 16'd5, 1'b0, 1'b0); // width >= period
        check("E idle out", 32'(ch_out), 32'h4);
        ch_en = 4'b1111;
        step();
        check("E start busy", 32'(ch_busy), 32'hd);
        check("E start wrap", 32'(ch_wrap), 32'hd);
        check("E start out", 32'(ch_out), 32'h4);
        for (int n = 0; n < 12; n++) begin
            trig = (n == 5) ? 4'b1111 : 4'b0000;
            step();
            e_out  = {1'b1, ~pat4[n % 4], 1'b0, ((n % 4) == 3)};
            e_wrap = {((n % 3) == 2), ((n % 4) == 3), 1'b0, ((n % 4) == 3)};
            check($sformatf("E out n=%0d", n), 32'(ch_out), 32'(e_out));
            check($sformatf("E wrap n=%0d", n), 32'(ch_wrap), 32'(e_wrap));
            check($sformatf("E busy n=%0d", n), 32'(ch_busy), 32'hd);
        end
        trig = '0;

        // F: ch_en drop mid-pulse keeps pending config; async reset mid-pulse
        do_reset(16'd0);
        load(0, 16'd4, 16'd1, 16'd2, 1'b0, 1'b0);
        load(1, 16'd4, 16'd1, 16'd2, 1'b0, 1'b0);
        ch_en = 4'b0011;
        step();
        for (int n = 0; n < 11; n++) begin
            if (n == 0) begin
                set_cfg(0, 16'd4, 16'd1, 16'd1, 1'b0, 1'b0);
                cfg_load[0] = 1'b1;
            end else begin
                cfg_load = '0;
            end
            if (n == 2) ch_en = 4'b0010;
            if (n == 4) ch_en = 4'b0011;
            step();
            check($sformatf("F out n=%0d", n), 32'(ch_out[1:0]), 32'(f_out[n]));
            check($sformatf("F busy n=%0d", n), 32'(ch_busy[1:0]), 32'(f_busy[n]));
        end
        rstn = 1'b0;
        #1;
        check("F async rst out", 32'(ch_out), 32'h0);
        check("F async rst busy", 32'(ch_busy), 32'h0);
        check("F async rst wrap", 32'(ch_wrap), 32'h0);
        rstn = 1'b1;
        step();
        check("F post rst out", 32'(ch_out), 32'h0);
        check("F post rst busy", 32'(ch_busy), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
